ah_div_result_buffer: RTL and testbench

Credit-managed result buffer that sits directly downstream of the 64-bit, 10-stage pipelined divider. The divider pipeline cannot stall, so this block owns flow control: it grants divider issue slots only when a result slot is guaranteed, captures every `data_valid` result with its `div_by_zero` flag into a FIFO, and presents results to the consumer over a valid/ready handshake.

---
 rtl/ah_div_result_buffer_if.sv | 23 ++
 rtl/ah_div_result_buffer.sv | 109 ++++++++++
 tb/tb_ah_div_result_buffer.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ah_div_result_buffer_if.sv
// Result stream between ah_div_result_buffer and its consumer (valid/ready).
interface ah_div_result_buffer_if #(
  parameter int unsigned WIDTH = 64
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic             out_div_by_zero;

  modport master (
    output out_valid,
    output out_quotient,
    output out_div_by_zero,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_quotient,
    input  out_div_by_zero,
    output out_ready
  );
endinterface

// File: rtl/ah_div_result_buffer.sv
// Credit-managed result FIFO behind the non-stalling pipelined divider.
// Optional same-cycle empty-FIFO bypass enabled by defining AH_DIV_RESULT_BYPASS_EN.
module ah_div_result_buffer #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  output logic                   div_start,
  input  logic                   div_data_valid,
  input  logic                   div_by_zero,
  input  logic [WIDTH-1:0]       div_quotient,
  ah_div_result_buffer_if.master out_if,
  output logic [CNT_W-1:0]       occupancy,
  output logic [CNT_W-1:0]       in_flight,
  output logic                   err_overflow,
  output logic                   err_unexpected
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned SUM_W = CNT_W + 1;
  localparam int unsigned ENT_W = WIDTH + 1;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [SUM_W-1:0] credit_sum;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             bypass_take;

  // A credit is any slot not already claimed by a stored or outstanding result.
  assign credit_sum  = SUM_W'(in_flight) + SUM_W'(count);
  assign issue_ready = !rst && (credit_sum < SUM_W'(DEPTH));
  assign div_start   = issue_valid && issue_ready;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign occupancy = count;

  // Head-of-FIFO presentation; zeros when nothing is available.
  always_comb begin
    out_if.out_valid       = 1'b0;
    out_if.out_quotient    = '0;
    out_if.out_div_by_zero = 1'b0;
    bypass_take            = 1'b0;
    if (!empty) begin
      out_if.out_valid = 1'b1;
      {out_if.out_div_by_zero, out_if.out_quotient} = mem[rd_ptr];
    end
`ifdef AH_DIV_RESULT_BYPASS_EN
    else if (div_data_valid && !rst) begin
      out_if.out_valid       = 1'b1;
      out_if.out_quotient    = div_quotient;
      out_if.out_div_by_zero = div_by_zero;
      bypass_take            = out_if.out_ready;
    end
`endif
  end

  assign pop  = !empty && out_if.out_ready;
  assign push = div_data_valid && !bypass_take && (!full || pop);

  // Storage array carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {div_by_zero, div_quotient};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      in_flight      <= '0;
      err_overflow   <= 1'b0;
      err_unexpected <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
      if (div_start && !div_data_valid) begin
        in_flight <= in_flight + CNT_W'(1);
      end else if (!div_start && div_data_valid && (in_flight != '0)) begin
        in_flight <= in_flight - CNT_W'(1);
      end
      if (div_data_valid && (in_flight == '0)) begin
        err_unexpected <= 1'b1;
      end
      if (div_data_valid && full && !pop) begin
        err_overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ah_div_result_buffer.sv
// Randomized bench for ah_div_result_buffer against a queue-based reference model.
`timescale 1ns/1ps
module tb_ah_div_result_buffer;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned LAT   = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             issue_valid;
  logic             issue_ready;
  logic             div_start;
  logic             div_data_valid;
  logic             div_by_zero;
  logic [WIDTH-1:0] div_quotient;
  logic [CNT_W-1:0] occupancy;
  logic [CNT_W-1:0] in_flight;
  logic             err_overflow;
  logic             err_unexpected;

  ah_div_result_buffer_if #(.WIDTH(WIDTH)) oif ();

  ah_div_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .issue_valid    (issue_valid),
    .issue_ready    (issue_ready),
    .div_start      (div_start),
    .div_data_valid (div_data_valid),
    .div_by_zero    (div_by_zero),
    .div_quotient   (div_quotient),
    .out_if         (oif),
    .occupancy      (occupancy),
    .in_flight      (in_flight),
    .err_overflow   (err_overflow),
    .err_unexpected (err_unexpected)
  );

  // Reference model: expected FIFO contents, outstanding count, sticky errors.
  logic [WIDTH:0]   m_q[$];
  int               m_inflight;
  bit               m_ovf;
  bit               m_unexp;
  // Behavioural divider: fixed-latency delay line of issued results.
  logic             pv [LAT];
  logic [WIDTH:0]   pd [LAT];
  bit               use_pipe;
  logic [WIDTH-1:0] nxt_q;
  logic             nxt_z;
  int               n_checks;
  int               n_errors;

  task automatic tick();
    bit start;
    bit pop;
    bit full;
    start = !rst && issue_valid && ((m_inflight + m_q.size()) < DEPTH);
    pop   = !rst && (m_q.size() != 0) && oif.out_ready;
    full  = (m_q.size() == DEPTH);
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_inflight = 0;
      m_ovf      = 1'b0;
      m_unexp    = 1'b0;
    end else begin
      if (div_data_valid && m_inflight == 0) m_unexp = 1'b1;
      if (start && !div_data_valid) m_inflight++;
      else if (div_data_valid && !start && m_inflight > 0) m_inflight--;
      if (pop) void'(m_q.pop_front());
      if (div_data_valid) begin
        if (!full || pop) m_q.push_back({div_by_zero, div_quotient});
        else m_ovf = 1'b1;
      end
    end
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i-1];
      pd[i] = pd[i-1];
    end
    pv[0] = start;
    pd[0] = {nxt_z, nxt_q};
    if (start) begin
      nxt_q = {$urandom(), $urandom()};
      nxt_z = ~nxt_z;
    end
    #1;
    if (use_pipe) begin
      div_data_valid = pv[LAT-1];
      {div_by_zero, div_quotient} = pd[LAT-1];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    issue_valid = 1'b1;
    out_ready_set(1'b0);
    tick();
    tick();
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_errors++; $display("FAIL reset_issue_ready: got %0h expected 0", issue_ready); end
    n_checks++; if (div_start !== 1'b0) begin n_errors++; $display("FAIL reset_div_start: got %0h expected 0", div_start); end
    n_checks++; if (oif.out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0h expected 0", oif.out_valid); end
    n_checks++; if (oif.out_quotient !== '0 || oif.out_div_by_zero !== 1'b0) begin n_errors++; $display("FAIL reset_out_data: got %0h/%0h expected 0/0", oif.out_quotient, oif.out_div_by_zero); end
    n_checks++; if (occupancy !== '0 || in_flight !== '0) begin n_errors++; $display("FAIL reset_counters: got occ %0d inf %0d expected 0 0", occupancy, in_flight); end
    n_checks++; if (err_overflow !== 1'b0 || err_unexpected !== 1'b0) begin n_errors++; $display("FAIL reset_errors: got %0h%0h expected 00", err_overflow, err_unexpected); end
    rst = 1'b0;
    issue_valid = 1'b0;
    #1;
    n_checks++; if (issue_ready !== 1'b1) begin n_errors++; $display("FAIL reset_release_ready: got %0h expected 1", issue_ready); end
  endtask

  task automatic out_ready_set(input logic v);
    oif.out_ready = v;
  endtask

  task automatic test_single();
    bit   seen;
    logic exp_z;
    use_pipe = 1'b1;
    out_ready_set(1'b1);
    nxt_q = 64'h0000_0000_0000_0007;
    exp_z = nxt_z;
    issue_valid = 1'b1;
    #1;
    n_checks++; if (div_start !== 1'b1) begin n_errors++; $display("FAIL single_start: got %0h expected 1", div_start); end
    tick();
    issue_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (div_data_valid) seen = 1'b1;
      else tick();
    end
    n_checks++; if (!seen) begin n_errors++; $display("FAIL single_timeout: got no result expected div_data_valid within 20 cycles"); end
    n_checks++; if (oif.out_valid !== 1'b0) begin n_errors++; $display("FAIL single_no_early_valid: got %0h expected 0", oif.out_valid); end
    tick();
    n_checks++; if (oif.out_valid !== 1'b1 || oif.out_quotient !== 64'd7 || oif.out_div_by_zero !== exp_z) begin n_errors++; $display("FAIL single_result: got v%0h q%0h z%0h expected v1 q7 z%0h", oif.out_valid, oif.out_quotient, oif.out_div_by_zero, exp_z); end
    n_checks++; if (in_flight !== '0) begin n_errors++; $display("FAIL single_in_flight: got %0d expected 0", in_flight); end
    tick();
    n_checks++; if (occupancy !== '0 || oif.out_valid !== 1'b0) begin n_errors++; $display("FAIL single_drained: got occ %0d v%0h expected 0 0", occupancy, oif.out_valid); end
  endtask

  task automatic test_credit();
    int starts;
    logic [WIDTH:0] exp_head;
    starts = 0;
    out_ready_set(1'b0);
    issue_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (div_start === 1'b1) starts++;
      n_checks++; if (issue_ready !== ((m_inflight + m_q.size()) < DEPTH)) begin n_errors++; $display("FAIL credit_ready_c%0d: got %0h expected %0h", i, issue_ready, (m_inflight + m_q.size()) < DEPTH); end
      tick();
    end
    n_checks++; if (starts != DEPTH) begin n_errors++; $display("FAIL credit_start_count: got %0d expected %0d", starts, DEPTH); end
    n_checks++; if (issue_ready !== 1'b0 || occupancy !== CNT_W'(DEPTH) || in_flight !== '0) begin n_errors++; $display("FAIL credit_full: got rdy %0h occ %0d inf %0d expected 0 16 0", issue_ready, occupancy, in_flight); end
    out_ready_set(1'b1);
    #1;
    exp_head = m_q[0];
    n_checks++; if ({oif.out_div_by_zero, oif.out_quotient} !== exp_head) begin n_errors++; $display("FAIL credit_head: got %0h expected %0h", {oif.out_div_by_zero, oif.out_quotient}, exp_head); end
    n_checks++; if (issue_ready !== 1'b0) begin n_errors++; $display("FAIL credit_no_comb_ready: got %0h expected 0", issue_ready); end
    tick();
    out_ready_set(1'b0);
    #1;
    n_checks++; if (issue_ready !== 1'b1 || div_start !== 1'b1) begin n_errors++; $display("FAIL credit_reissue: got rdy %0h start %0h expected 1 1", issue_ready, div_start); end
    tick();
    #1;
    n_checks++; if (issue_ready !== 1'b0) begin n_errors++; $display("FAIL credit_single_reissue: got %0h expected 0", issue_ready); end
    issue_valid = 1'b0;
    for (int i = 0; i < LAT + 2; i++) tick();
    n_checks++; if (occupancy !== CNT_W'(DEPTH) || in_flight !== '0) begin n_errors++; $display("FAIL credit_refill: got occ %0d inf %0d expected 16 0", occupancy, in_flight); end
  endtask

  task automatic test_full_push_pop();
    logic [WIDTH:0] exp_head;
    use_pipe = 1'b0;
    div_data_valid = 1'b1;
    div_quotient = {$urandom(), $urandom()};
    div_by_zero = 1'b1;
    out_ready_set(1'b1);
    #1;
    exp_head = m_q[0];
    n_checks++; if ({oif.out_div_by_zero, oif.out_quotient} !== exp_head) begin n_errors++; $display("FAIL fpp_head: got %0h expected %0h", {oif.out_div_by_zero, oif.out_quotient}, exp_head); end
    tick();
    div_data_valid = 1'b0;
    out_ready_set(1'b0);
    #1;
    n_checks++; if (occupancy !== CNT_W'(m_q.size()) || m_q.size() != DEPTH) begin n_errors++; $display("FAIL fpp_occupancy: got %0d expected %0d", occupancy, DEPTH); end
    n_checks++; if (err_overflow !== 1'b0) begin n_errors++; $display("FAIL fpp_no_overflow: got %0h expected 0", err_overflow); end
    n_checks++; if (err_unexpected !== m_unexp) begin n_errors++; $display("FAIL fpp_unexpected: got %0h expected %0h", err_unexpected, m_unexp); end
  endtask

  task automatic test_overflow();
    logic [WIDTH:0] exp_head;
    use_pipe = 1'b0;
    div_data_valid = 1'b1;
    div_quotient = {$urandom(), $urandom()};
    div_by_zero = 1'b0;
    out_ready_set(1'b0);
    tick();
    div_data_valid = 1'b0;
    #1;
    n_checks++; if (occupancy !== CNT_W'(DEPTH) || err_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_set: got occ %0d ovf %0h expected 16 1", occupancy, err_overflow); end
    for (int i = 0; i < 3; i++) tick();
    n_checks++; if (err_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_sticky: got %0h expected 1", err_overflow); end
    out_ready_set(1'b1);
    for (int i = 0; i < 40 && m_q.size() != 0; i++) begin
      #1;
      exp_head = m_q[0];
      n_checks++; if (oif.out_valid !== 1'b1 || {oif.out_div_by_zero, oif.out_quotient} !== exp_head) begin n_errors++; $display("FAIL ovf_drain_%0d: got v%0h %0h expected v1 %0h", i, oif.out_valid, {oif.out_div_by_zero, oif.out_quotient}, exp_head); end
      tick();
    end
    n_checks++; if (occupancy !== '0 || err_overflow !== 1'b1) begin n_errors++; $display("FAIL ovf_after_drain: got occ %0d ovf %0h expected 0 1", occupancy, err_overflow); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (err_overflow !== 1'b0 || err_unexpected !== 1'b0) begin n_errors++; $display("FAIL ovf_reset_clear: got %0h%0h expected 00", err_overflow, err_unexpected); end
  endtask

  task automatic test_wrap();
    int issued;
    int popped;
    bit exp_start;
    logic [WIDTH:0] exp_head;
    issued = 0;
    popped = 0;
    use_pipe = 1'b1;
    for (int cyc = 0; cyc < 2000 && (issued < 40 || m_q.size() != 0 || m_inflight != 0); cyc++) begin
      issue_valid = (issued < 40) && ($urandom_range(0, 3) != 0);
      out_ready_set(1'($urandom_range(0, 1)));
      #1;
      exp_start = issue_valid && ((m_inflight + m_q.size()) < DEPTH);
      n_checks++; if (div_start !== exp_start) begin n_errors++; $display("FAIL wrap_start_c%0d: got %0h expected %0h", cyc, div_start, exp_start); end
      n_checks++; if (occupancy !== CNT_W'(m_q.size()) || in_flight !== CNT_W'(m_inflight)) begin n_errors++; $display("FAIL wrap_counts_c%0d: got occ %0d inf %0d expected %0d %0d", cyc, occupancy, in_flight, m_q.size(), m_inflight); end
      if (m_q.size() != 0 && oif.out_ready) begin
        exp_head = m_q[0];
        n_checks++; if (oif.out_valid !== 1'b1 || {oif.out_div_by_zero, oif.out_quotient} !== exp_head) begin n_errors++; $display("FAIL wrap_data_%0d: got v%0h %0h expected v1 %0h", popped, oif.out_valid, {oif.out_div_by_zero, oif.out_quotient}, exp_head); end
        popped++;
      end
      if (exp_start) issued++;
      tick();
    end
    issue_valid = 1'b0;
    out_ready_set(1'b0);
    n_checks++; if (popped != 40) begin n_errors++; $display("FAIL wrap_popped: got %0d expected 40", popped); end
    n_checks++; if (err_overflow !== 1'b0 || err_unexpected !== 1'b0) begin n_errors++; $display("FAIL wrap_errors: got %0h%0h expected 00", err_overflow, err_unexpected); end
  endtask

  task automatic test_spurious();
    logic [WIDTH-1:0] q;
    q = {$urandom(), $urandom()};
    use_pipe = 1'b0;
    div_data_valid = 1'b1;
    div_quotient = q;
    div_by_zero = 1'b1;
    out_ready_set(1'b1);
    tick();
    div_data_valid = 1'b0;
    #1;
    n_checks++; if (err_unexpected !== 1'b1 || in_flight !== '0) begin n_errors++; $display("FAIL spur_flags: got unexp %0h inf %0d expected 1 0", err_unexpected, in_flight); end
    n_checks++; if (oif.out_valid !== 1'b1 || oif.out_quotient !== q || oif.out_div_by_zero !== 1'b1) begin n_errors++; $display("FAIL spur_delivered: got v%0h q%0h z%0h expected v1 q%0h z1", oif.out_valid, oif.out_quotient, oif.out_div_by_zero, q); end
    tick();
    n_checks++; if (occupancy !== '0 || err_unexpected !== 1'b1) begin n_errors++; $display("FAIL spur_after: got occ %0d unexp %0h expected 0 1", occupancy, err_unexpected); end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    m_inflight = 0;
    m_ovf = 1'b0;
    m_unexp = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    use_pipe = 1'b1;
    nxt_q = '0;
    nxt_z = 1'b0;
    rst = 1'b1;
    issue_valid = 1'b0;
    div_data_valid = 1'b0;
    div_by_zero = 1'b0;
    div_quotient = '0;
    oif.out_ready = 1'b0;
    test_reset();
    test_single();
    test_credit();
    test_full_push_pop();
    test_overflow();
    test_wrap();
    test_spurious();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
